// File: rtl/ro_count_sampler.sv
// Ring-oscillator edge counter: counts synchronised RO rising edges over a
// window of clk cycles and emits one sample per window for the transfer stage.
module ro_count_sampler #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int DEFAULT_WINDOW = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ro_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           window_len,
  input  logic [15:0]           settle_cycles,
  input  logic [31:0]           num_meas,
  output logic                  ro_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_en,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           meas_count,
  output logic                  overflow
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] COUNT  = 3'd2;
  localparam logic [2:0] EMIT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  logic [2:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   rise;
  logic [31:0]            window_q;
  logic [31:0]            num_meas_q;
  logic [31:0]            win_cnt;
  logic [15:0]            settle_cnt;
  logic [DATA_WIDTH-1:0]  edge_cnt;
  logic [DATA_WIDTH-1:0]  count_next;
  logic                   sat_hit;
  logic [31:0]            meas_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Saturating increment; a rise at full scale flags overflow instead of wrapping.
  always_comb begin
    count_next = edge_cnt;
    sat_hit    = 1'b0;
    if (rise) begin
      if (edge_cnt == CNT_MAX) sat_hit = 1'b1;
      else                     count_next = edge_cnt + 1'b1;
    end
  end

  assign meas_next = meas_count + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      window_q   <= 32'd0;
      num_meas_q <= 32'd0;
      win_cnt    <= 32'd0;
      settle_cnt <= 16'd0;
      edge_cnt   <= '0;
      data_out   <= '0;
      meas_count <= 32'd0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            window_q   <= (window_len == 32'd0) ? 32'(DEFAULT_WINDOW) : window_len;
            settle_cnt <= settle_cycles;
            num_meas_q <= num_meas;
            meas_count <= 32'd0;
            overflow   <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (stop) begin
            state <= IDLE;
          end else if (settle_cnt == 16'd0) begin
            win_cnt  <= 32'd0;
            edge_cnt <= '0;
            state    <= COUNT;
          end else begin
            settle_cnt <= settle_cnt - 16'd1;
          end
        end
        // The sample is captured on the last COUNT edge so it is already valid during EMIT.
        COUNT: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            edge_cnt <= count_next;
            if (sat_hit) overflow <= 1'b1;
            if (win_cnt == window_q - 32'd1) begin
              data_out <= count_next;
              state    <= EMIT;
            end else begin
              win_cnt <= win_cnt + 32'd1;
            end
          end
        end
        EMIT: begin
          meas_count <= meas_next;
          if (stop) begin
            state <= IDLE;
          end else if (num_meas_q != 32'd0 && meas_next == num_meas_q) begin
            state <= DONE;
          end else begin
            win_cnt  <= 32'd0;
            edge_cnt <= '0;
            state    <= COUNT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ro_enable = (state == SETTLE) || (state == COUNT) || (state == EMIT);
  assign busy      = (state != IDLE);
  assign data_en   = (state == EMIT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_ro_count_sampler.sv
// Directed bench for ro_count_sampler: expected samples and their cycle of
// arrival are queued when a run is started and checked on each data_en.
module tb_ro_count_sampler;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } sample_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ro_in = 1'b0;
  logic        ro_in4 = 1'b0;
  logic        start, stop;
  logic [31:0] window_len;
  logic [15:0] settle_cycles;
  logic [31:0] num_meas;
  logic        ro_enable, data_en, busy, done, overflow;
  logic [31:0] data_out, meas_count;
  logic        ro_enable4, data_en4, busy4, done4, overflow4;
  logic [3:0]  data_out4;
  logic [31:0] meas_count4;

  int          test_count = 0;
  int          fail_count = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = -1;
  int          ro_phase = 0;
  bit          ro_mode = 1'b0;
  sample_t     sb[$];
  int          k, d0;

  ro_count_sampler dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .stop(stop),
    .window_len(window_len), .settle_cycles(settle_cycles), .num_meas(num_meas),
    .ro_enable(ro_enable), .data_out(data_out), .data_en(data_en), .busy(busy),
    .done(done), .meas_count(meas_count), .overflow(overflow)
  );

  ro_count_sampler #(.DATA_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ro_in(ro_in4), .start(start), .stop(stop),
    .window_len(window_len), .settle_cycles(settle_cycles), .num_meas(num_meas),
    .ro_enable(ro_enable4), .data_out(data_out4), .data_en(data_en4), .busy(busy4),
    .done(done4), .meas_count(meas_count4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ro_in: 10-clk period when enabled, else low; ro_in4: 2-clk period always.
  always @(negedge clk) begin
    ro_in4 = ~ro_in4;
    if (ro_mode) begin
      ro_phase++;
      if (ro_phase == 5) begin
        ro_phase = 0;
        ro_in = ~ro_in;
      end
    end else begin
      ro_phase = 0;
      ro_in = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] win, input logic [15:0] settle,
                               input logic [31:0] num, output int t0);
    window_len    = win;
    settle_cycles = settle;
    num_meas      = num;
    start         = 1'b1;
    t0            = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_expect(input logic [31:0] val, input int at_cyc);
    sample_t s;
    s.val = val;
    s.cyc = at_cyc;
    sb.push_back(s);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (data_en === 1'b1) begin
      checkOutput("sb_has_entry_at_emit", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        sample_t s;
        s = sb.pop_front();
        checkOutput("data_out", data_out, s.val);
        checkOutput("emit_cycle", 32'(cyc), 32'(s.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    window_len = 32'd0; settle_cycles = 16'd0; num_meas = 32'd0;
    wait_cycles(3);
    checkOutput("rst_ro_enable", 32'(ro_enable), 32'd0);
    checkOutput("rst_data_out", data_out, 32'd0);
    checkOutput("rst_data_en", 32'(data_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_meas_count", meas_count, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Three windows of 100 cycles, period-10 RO: exactly 10 edges each.
    ro_mode = 1'b1;
    wait_cycles(20);
    d0 = done_cnt;
    applyStimulus(32'd100, 16'd5, 32'd3, k);
    for (int i = 0; i < 3; i++) push_expect(32'd10, k + 107 + i * 101);
    wait_cycles(310);
    checkOutput("t1_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    checkOutput("t1_done_cycle", 32'(last_done_cyc), 32'(k + 310));
    checkOutput("t1_meas_count", meas_count, 32'd3);
    checkOutput("t1_ro_enable", 32'(ro_enable), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_overflow", 32'(overflow), 32'd0);

    // Default window with a silent RO.
    ro_mode = 1'b0;
    wait_cycles(10);
    d0 = done_cnt;
    applyStimulus(32'd0, 16'd0, 32'd1, k);
    push_expect(32'd0, k + 1002);
    wait_cycles(1003);
    checkOutput("t2_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
    checkOutput("t2_done_cycle", 32'(last_done_cyc), 32'(k + 1003));
    checkOutput("t2_meas_count", meas_count, 32'd1);
    checkOutput("t2_overflow", 32'(overflow), 32'd0);

    // 4-bit instance: 32 edges in 64 cycles saturates; next start clears overflow.
    applyStimulus(32'd64, 16'd0, 32'd1, k);
    push_expect(32'd0, k + 66);
    wait_cycles(67);
    checkOutput("t3_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("t3_data_out4_sat", 32'(data_out4), 32'd15);
    checkOutput("t3_overflow4_set", 32'(overflow4), 32'd1);
    checkOutput("t3_overflow_main", 32'(overflow), 32'd0);
    applyStimulus(32'd10, 16'd0, 32'd1, k);
    checkOutput("t3_overflow4_cleared", 32'(overflow4), 32'd0);
    push_expect(32'd0, k + 12);
    wait_cycles(13);
    checkOutput("t3_data_out4_small", 32'(data_out4), 32'd5);
    checkOutput("t3_overflow4_stays", 32'(overflow4), 32'd0);
    checkOutput("t3b_sb_drained", 32'(sb.size()), 32'd0);

    // Continuous mode, stop in the middle of the 4th window.
    ro_mode = 1'b1;
    wait_cycles(20);
    d0 = done_cnt;
    applyStimulus(32'd20, 16'd2, 32'd0, k);
    for (int i = 0; i < 3; i++) push_expect(32'd2, k + 24 + i * 21);
    wait_cycles(74);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("t4_ro_enable_after_stop", 32'(ro_enable), 32'd0);
    checkOutput("t4_busy_after_stop", 32'(busy), 32'd0);
    checkOutput("t4_meas_count", meas_count, 32'd3);
    checkOutput("t4_data_out_held", data_out, 32'd2);
    wait_cycles(30);
    checkOutput("t4_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // start together with stop in IDLE is ignored.
    window_len = 32'd7; settle_cycles = 16'd0; num_meas = 32'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checkOutput("t5_startstop_busy", 32'(busy), 32'd0);
    checkOutput("t5_startstop_ro_enable", 32'(ro_enable), 32'd0);
    checkOutput("t5_startstop_meas_count", meas_count, 32'd3);
    wait_cycles(5);
    checkOutput("t5_startstop_still_idle", 32'(busy), 32'd0);

    // start while busy is ignored: the run keeps its latched window and count.
    d0 = done_cnt;
    applyStimulus(32'd20, 16'd0, 32'd2, k);
    push_expect(32'd2, k + 22);
    push_expect(32'd2, k + 43);
    wait_cycles(10);
    window_len = 32'd5; num_meas = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(33);
    checkOutput("t5_busy_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("t5_busy_done_pulses", 32'(done_cnt - d0), 32'd1);
    checkOutput("t5_busy_done_cycle", 32'(last_done_cyc), 32'(k + 44));
    checkOutput("t5_busy_meas_count", meas_count, 32'd2);

    // Reset in the middle of COUNT, then a fresh run.
    applyStimulus(32'd50, 16'd0, 32'd0, k);
    wait_cycles(19);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_ro_enable", 32'(ro_enable), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_data_out", data_out, 32'd0);
    checkOutput("t6_rst_data_en", 32'(data_en), 32'd0);
    checkOutput("t6_rst_done", 32'(done), 32'd0);
    checkOutput("t6_rst_meas_count", meas_count, 32'd0);
    checkOutput("t6_rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    wait_cycles(10);
    d0 = done_cnt;
    applyStimulus(32'd30, 16'd1, 32'd1, k);
    push_expect(32'd3, k + 33);
    wait_cycles(34);
    checkOutput("t6_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
    checkOutput("t6_meas_count", meas_count, 32'd1);
    checkOutput("t6_data_out", data_out, 32'd3);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
